// File: rtl/core_out_display.sv
// Converts the core's 8-bit output to three BCD digits with a sequential
// double-dabble engine and scans them onto a common-anode seven-segment display.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros on the hundreds/tens digits.
module core_out_display #(
   parameter int SCAN_DIV = 50000,
   parameter int CNT_W    = 16
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [7:0]  value_in,
   output logic [6:0]  seg,
   output logic [2:0]  an,
   output logic [11:0] bcd,
   output logic        busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CONV = 2'd1;
   localparam logic [1:0] LOAD = 2'd2;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

   logic [1:0]       state_q, state_d;
   logic [7:0]       lastValue_q, lastValue_d;
   logic [7:0]       shift_q, shift_d;
   logic [11:0]      work_q, work_d;
   logic [2:0]       bitCnt_q, bitCnt_d;
   logic [11:0]      bcd_q, bcd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [2:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic [11:0]      workAdj;
   logic [3:0]       digit;
   logic             blank;

   function automatic logic [3:0] addThree(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] segDecode(input logic [3:0] n);
      case (n)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   assign workAdj = {addThree(work_q[11:8]), addThree(work_q[7:4]), addThree(work_q[3:0])};

   // Converter FSM: new values are only sampled in IDLE, so changes during a
   // conversion are dropped and the latest stable value is picked up afterwards.
   always_comb begin
      state_d     = state_q;
      lastValue_d = lastValue_q;
      shift_d     = shift_q;
      work_d      = work_q;
      bitCnt_d    = bitCnt_q;
      bcd_d       = bcd_q;
      case (state_q)
         IDLE: begin
            if (value_in != lastValue_q) begin
               lastValue_d = value_in;
               shift_d     = value_in;
               work_d      = 12'h000;
               bitCnt_d    = 3'd0;
               state_d     = CONV;
            end
         end
         CONV: begin
            {work_d, shift_d} = {workAdj[10:0], shift_q, 1'b0};
            bitCnt_d          = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            bcd_d   = work_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == LAST_CNT) begin
         idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
   end

   always_comb begin
      case (idx_q)
         2'd0:    digit = bcd_q[3:0];
         2'd1:    digit = bcd_q[7:4];
         default: digit = bcd_q[11:8];
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      blank = ((idx_q == 2'd2) && (bcd_q[11:8] == 4'd0)) ||
              ((idx_q == 2'd1) && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0));
`else
      blank = 1'b0;
`endif
      an_d  = ~(3'b001 << idx_q);
      seg_d = blank ? 7'b1111111 : segDecode(digit);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         lastValue_q <= 8'd0;
         shift_q     <= 8'd0;
         work_q      <= 12'h000;
         bitCnt_q    <= 3'd0;
         bcd_q       <= 12'h000;
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         an_q        <= 3'b111;
         seg_q       <= 7'b1111111;
      end else begin
         state_q     <= state_d;
         lastValue_q <= lastValue_d;
         shift_q     <= shift_d;
         work_q      <= work_d;
         bitCnt_q    <= bitCnt_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign bcd  = bcd_q;
   assign an   = an_q;
   assign seg  = seg_q;

endmodule
